regfile_mp_scoreboard: RTL and testbench

- Parametrised multi-port integer register file with per-register pending-write scoreboard and optional write-to-read bypass.
- Next-generation GPR array for the pipelined core. It serves the decode stage (reads and hazard query), issue (marks destination busy) and writeback (commits data and clears busy).
- Register 0 is hardwired to zero, is never written and is never busy.

---
 rtl/regfile_mp_scoreboard.sv | 84 ++++++++
 tb/tb_regfile_mp_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port GPR array with a per-register pending-write scoreboard.
// x0 reads as zero and is never busy; BYPASS forwards same-cycle write data to the reads.
module regfile_mp_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]      raddr,
  output logic [NREAD*DATA_WIDTH-1:0]      rdata,
  output logic [NREAD-1:0]                 rbusy,
  input  logic [NWRITE-1:0]                we,
  input  logic [NWRITE*ADDR_WIDTH-1:0]     waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0]     wdata,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_rd,
  output logic                             issue_stall,
  output logic [(1<<ADDR_WIDTH)-1:0]       busy_vec
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  // Later write ports override earlier ones; an issue supersedes a same-cycle writeback clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j]) begin
        regs_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        busy_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] fwd_s;

    assign ra_s = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    // Highest-index matching write port wins the forward.
    always_comb begin
      hit_s = 1'b0;
      fwd_s = regs_q[ra_s];
      for (int j = 0; j < NWRITE; j++) begin
        if ((BYPASS != 0) && we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra_s)) begin
          hit_s = 1'b1;
          fwd_s = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = (ra_s == '0) ? '0 : fwd_s;
    assign rbusy[gi] = (ra_s != '0) && busy_q[ra_s] && !hit_s;
  end

  assign issue_stall = issue_valid && (issue_rd != '0) && busy_q[issue_rd];
  assign busy_vec    = busy_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench: directed plan items plus randomized traffic, checked against a behavioural model.
// Two instances share the stimulus: one with forwarding and one without.
module tb_regfile_mp_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;

  logic [NR*DW-1:0] rdata_b1, rdata_b0;
  logic [NR-1:0]    rbusy_b1, rbusy_b0;
  logic             stall_b1, stall_b0;
  logic [31:0]      busyv_b1, busyv_b0;

  int total = 0;
  int bad   = 0;
  bit inited = 1'b0;

  logic [DW-1:0] mem [32];
  bit            bsy [32];

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b1), .rbusy(rbusy_b1),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(stall_b1), .busy_vec(busyv_b1));

  regfile_mp_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(0)) u0 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b0), .rbusy(rbusy_b0),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(stall_b0), .busy_vec(busyv_b0));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit written(input int a);
    bit w = 1'b0;
    for (int j = 0; j < NW; j++)
      if (we[j] && int'(waddr[j*AW +: AW]) == a) w = 1'b1;
    return w;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int a, input bit byp);
    logic [DW-1:0] r;
    if (a == 0) return '0;
    r = mem[a];
    if (byp)
      for (int j = 0; j < NW; j++)
        if (we[j] && int'(waddr[j*AW +: AW]) == a) r = wdata[j*DW +: DW];
    return r;
  endfunction

  function automatic logic [31:0] m_busyvec();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = bsy[r];
    return v;
  endfunction

  task automatic compare_model();
    bit exp_stall;
    for (int i = 0; i < NR; i++) begin
      int a = int'(raddr[i*AW +: AW]);
      if (!rst) begin
        chk($sformatf("rdata_byp[%0d]", i), 64'(rdata_b1[i*DW +: DW]), 64'(m_rd(a, 1'b1)));
        chk($sformatf("rdata_nobyp[%0d]", i), 64'(rdata_b0[i*DW +: DW]), 64'(m_rd(a, 1'b0)));
      end
      chk($sformatf("rbusy_byp[%0d]", i), 64'(rbusy_b1[i]), 64'((a != 0) && bsy[a] && !written(a)));
      chk($sformatf("rbusy_nobyp[%0d]", i), 64'(rbusy_b0[i]), 64'((a != 0) && bsy[a]));
    end
    exp_stall = issue_valid && (issue_rd != 5'd0) && bsy[int'(issue_rd)];
    chk("stall_byp", 64'(stall_b1), 64'(exp_stall));
    chk("stall_nobyp", 64'(stall_b0), 64'(exp_stall));
    chk("busy_vec_byp", 64'(busyv_b1), 64'(m_busyvec()));
    chk("busy_vec_nobyp", 64'(busyv_b0), 64'(m_busyvec()));
  endtask

  task automatic model_update();
    bit nb [32];
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mem[r] = '0; bsy[r] = 1'b0; end
      inited = 1'b1;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_valid && int'(issue_rd) == r) nb[r] = 1'b1;
        else if (written(r)) nb[r] = 1'b0;
        else nb[r] = bsy[r];
      end
      for (int j = 0; j < NW; j++)
        if (we[j] && waddr[j*AW +: AW] != 5'd0) mem[int'(waddr[j*AW +: AW])] = wdata[j*DW +: DW];
      for (int r = 1; r < 32; r++) bsy[r] = nb[r];
    end
  endtask

  // Inputs change on the falling edge; settle() checks mid low-phase, tick() crosses the rising edge.
  task automatic setin(input bit r, input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1, input bit iv, input logic [4:0] ird,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; we = w; waddr = {wa1, wa0}; wdata = {wd1, wd0};
    issue_valid = iv; issue_rd = ird; raddr = {ra1, ra0};
  endtask

  task automatic settle();
    #2;
    if (inited) compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    setin(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    settle(); tick();
    // Reset with simultaneous writes: writes lost
    setin(1'b1, 2'b11, 5'd5, 32'h5555_0005, 5'd6, 32'h6666_0006, 1'b1, 5'd8, 5'd5, 5'd6);
    settle(); tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd6);
    settle();
    chk("reset_x5", 64'(rdata_b1[31:0]), 64'h0);
    chk("reset_x6", 64'(rdata_b1[63:32]), 64'h0);
    chk("reset_busy", 64'(busyv_b1), 64'h0);
    tick();
    // Write/read bypass vs stored
    setin(1'b0, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    settle();
    chk("byp_same_cycle", 64'(rdata_b1[31:0]), 64'hDEAD_BEEF);
    chk("nobyp_same_cycle", 64'(rdata_b0[31:0]), 64'h0);
    tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    settle();
    chk("nobyp_next_cycle", 64'(rdata_b0[31:0]), 64'hDEAD_BEEF);
    tick();
    // x0 protection
    setin(1'b0, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    chk("x0_read", 64'(rdata_b1[31:0]), 64'h0);
    chk("x0_stall", 64'(stall_b1), 64'h0);
    tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    chk("x0_busy", 64'(busyv_b1[0]), 64'h0);
    chk("x0_stored", 64'(rdata_b0[31:0]), 64'h0);
    tick();
    // Dual-write collision
    setin(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd0);
    settle();
    chk("collide_byp", 64'(rdata_b1[31:0]), 64'h22);
    tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    settle();
    chk("collide_stored", 64'(rdata_b0[31:0]), 64'h22);
    tick();
    // Scoreboard set / stall / writeback clear
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    settle(); tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    settle();
    chk("busy9_set", 64'(busyv_b1[9]), 64'h1);
    chk("rbusy9", 64'(rbusy_b1[0]), 64'h1);
    chk("stall9", 64'(stall_b1), 64'h1);
    tick();
    setin(1'b0, 2'b01, 5'd9, 32'h0000_0999, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    settle();
    chk("wb9_rbusy_byp", 64'(rbusy_b1[0]), 64'h0);
    chk("wb9_rdata_byp", 64'(rdata_b1[31:0]), 64'h999);
    chk("wb9_rbusy_nobyp", 64'(rbusy_b0[0]), 64'h1);
    tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    settle();
    chk("busy9_clear", 64'(busyv_b1[9]), 64'h0);
    tick();
    // Issue/clear race on x4
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 5'd0);
    settle(); tick();
    setin(1'b0, 2'b10, 5'd0, 32'd0, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 5'd4, 5'd0);
    settle(); tick();
    setin(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd0);
    settle();
    chk("race_busy4", 64'(busyv_b1[4]), 64'h1);
    chk("race_data4", 64'(rdata_b0[31:0]), 64'h44);
    tick();
    // Randomized traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      setin(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle(); tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
